// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
// Holds the controller state encoding and the slice width the datapath walks in.
// Latency/backpressure: n/a (types and constants only).
package seq_mag_cmp_pkg;

    // Slice width consumed per RUN cycle.
    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mag_cmp_cmp2.sv
// Combinational 2-bit unsigned comparator stage: reports slice equality and a > b.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow the inputs continuously.
// Ports: a_i/b_i slice operands; eq_o = (a_i == b_i); gt_o = (a_i > b_i).
module seq_mag_cmp_cmp2
    import seq_mag_cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output logic               eq_o,
    output logic               gt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle unsigned magnitude comparator walking operands MSB-first, 2 bits per cycle.
// Latency: done pulses the cycle after the deciding slice's edge (1..WIDTH/2 edges after start).
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, not queued.
// Ports: clk, rst (async, active-high); start/A/B request + operands; busy (state != IDLE);
//        done (1-cycle result pulse); EQ/GT/LT registered relation; slices = slices examined.
module seq_mag_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    output logic                       busy,
    output logic                       done,
    output logic                       EQ,
    output logic                       GT,
    output logic                       LT,
    output logic [$clog2(WIDTH/2):0]   slices
);

    localparam int NSL  = WIDTH / SLICE_W;
    localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int SLW  = $clog2(NSL) + 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("seq_mag_cmp: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              eq_q, eq_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic [SLW-1:0]    slices_q, slices_d;

    logic [SLICE_W-1:0] sl_a, sl_b;
    logic               sl_eq, sl_gt;
    logic [SLW-1:0]     slices_now;

    // Current slice: bit offset is idx*2, formed by appending a zero bit.
    assign sl_a = ra_q[{idx_q, 1'b0} +: SLICE_W];
    assign sl_b = rb_q[{idx_q, 1'b0} +: SLICE_W];

    seq_mag_cmp_cmp2 u_cmp2 (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .eq_o (sl_eq),
        .gt_o (sl_gt)
    );

    // Slices examined so far, counting the current one: WIDTH/2 - idx.
    assign slices_now = SLW'(NSL) - SLW'(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            idx_q    <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            slices_q <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            idx_q    <= idx_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            slices_q <= slices_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        idx_d    = idx_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        slices_d = slices_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d     = A;
                    rb_d     = B;
                    idx_d    = IDXW'(NSL - 1);
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    slices_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!sl_eq) begin
                    // First unequal slice settles the relation; LT is neither EQ nor GT.
                    gt_d     = sl_gt;
                    lt_d     = ~sl_eq & ~sl_gt;
                    slices_d = slices_now;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    eq_d     = 1'b1;
                    slices_d = slices_now;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign EQ     = eq_q;
    assign GT     = gt_q;
    assign LT     = lt_q;
    assign slices = slices_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
module tb_seq_mag_cmp;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic       EQ;
    logic       GT;
    logic       LT;
    logic [2:0] slices;

    int vectors;
    int miscompares;

    seq_mag_cmp #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .EQ     (EQ),
        .GT     (GT),
        .LT     (LT),
        .slices (slices)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: number of MSB-first 2-bit slices needed to decide (all 4 when equal).
    function automatic int ref_slices(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] diff;
        diff = a ^ b;
        for (int i = 3; i >= 0; i--) begin
            if (diff[2*i +: 2] != 2'b00) return 4 - i;
        end
        return 4;
    endfunction

    // Reference relation packed as {EQ, GT, LT}.
    function automatic logic [2:0] ref_rel(input logic [7:0] a, input logic [7:0] b);
        if (a == b) return 3'b100;
        if (a > b)  return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full compare: start, scramble operands, wait for done, check result and timing.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        int k;
        logic [2:0] rel;
        k   = ref_slices(a, b);
        rel = ref_rel(a, b);
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        check({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
        check({tag, " rel clear in RUN"}, {29'd0, EQ, GT, LT}, 32'd0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, " done latency"}, n, k);
        check({tag, " relation"}, {29'd0, EQ, GT, LT}, {29'd0, rel});
        check({tag, " slices"}, {29'd0, slices}, k);
        tick();
        check({tag, " done single pulse"}, {31'd0, done}, 32'd0);
        check({tag, " busy low"}, {31'd0, busy}, 32'd0);
        check({tag, " relation held"}, {29'd0, EQ, GT, LT}, {29'd0, rel});
    endtask

    initial begin
        int dcount;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        #2;
        check("reset outputs", {25'd0, busy, done, EQ, GT, LT, slices}, 32'd0);
        #10;
        rst = 1'b0;
        tick();
        check("idle after reset", {25'd0, busy, done, EQ, GT, LT, slices}, 32'd0);

        // Directed vectors.
        run_cmp(8'hA5, 8'h5A, "A5>5A");
        run_cmp(8'h3C, 8'h3C, "3C==3C");
        run_cmp(8'h12, 8'h13, "12<13");
        run_cmp(8'h40, 8'h7F, "40<7F");
        run_cmp(8'h00, 8'h00, "zero");
        run_cmp(8'hFF, 8'hFE, "FF>FE");

        // Outputs held across idle cycles with no start.
        repeat (3) tick();
        check("hold idle", {26'd0, EQ, GT, LT, slices}, {26'd0, 3'b010, 3'd4});

        // start/A/B churn during RUN and DONE must not disturb or restart.
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        tick();
        A = 8'h00;
        B = 8'hFF;
        tick();
        check("churn done", {31'd0, done}, 32'd1);
        check("churn rel", {26'd0, EQ, GT, LT, slices}, {26'd0, 3'b010, 3'd1});
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dcount++;
            check("churn no restart busy", {31'd0, busy}, 32'd0);
        end
        check("churn no extra done", dcount, 0);

        // Asynchronous reset mid-compare.
        A = 8'h3C;
        B = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async reset outputs", {25'd0, busy, done, EQ, GT, LT, slices}, 32'd0);
        #4;
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dcount++;
        end
        check("no done after reset", dcount, 0);
        check("idle after mid reset", {31'd0, busy}, 32'd0);
        run_cmp(8'h01, 8'h00, "01>00 post reset");

        // Randomized compares, biased toward shared prefixes.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ra ^ (8'($urandom) >> $urandom_range(0, 8));
            run_cmp(ra, rb, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
